// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: in-order {instruction, address}
// entries with valid/ready on both sides and a flush that discards everything.
module if_id_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instruction,
  input  logic [63:0]                in_address,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instruction,
  output logic [63:0]                out_address,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = 32;
  localparam int unsigned AW = 64;

  logic [IW-1:0] insn_mem [DEPTH];
  logic [AW-1:0] addr_mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic full_c;
  logic empty_c;
  logic push_c;
  logic pop_c;

  // Flags depend on registered occupancy only, so in_ready never sees out_ready.
  always_comb begin
    full_c  = (count_q == CW'(DEPTH));
    empty_c = (count_q == '0);
    push_c  = in_valid & ~full_c & ~flush;
    pop_c   = ~empty_c & out_ready & ~flush;
  end

  // Pointer and occupancy next-state; flush overrides any handshake.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = PW'(wr_ptr_q + PW'(1));
      end
      if (pop_c) begin
        rd_ptr_d = PW'(rd_ptr_q + PW'(1));
      end
      case ({push_c, pop_c})
        2'b10:   count_d = CW'(count_q + CW'(1));
        2'b01:   count_d = CW'(count_q - CW'(1));
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; only occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (push_c) begin
      insn_mem[wr_ptr_q] <= in_instruction;
      addr_mem[wr_ptr_q] <= in_address;
    end
  end

  always_comb begin
    in_ready        = ~full_c;
    out_valid       = ~empty_c;
    count           = count_q;
    out_instruction = NOP_INSN;
    out_address     = '0;
    if (!empty_c) begin
      out_instruction = insn_mem[rd_ptr_q];
      out_address     = addr_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=2): reset, single entry, full stall,
// push+pop, flush priority, async reset mid-cycle and an ordered wrap stream.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instruction;
  logic [63:0]   in_address;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instruction;
  logic [63:0]   out_address;
  logic [CW-1:0] count;

  int n_checks;
  int n_fail;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_address      (in_address),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_address     (out_address),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic r, input logic f);
    in_valid       = v;
    in_address     = a;
    in_instruction = 32'h00A00013 + 32'(a);
    out_ready      = r;
    flush          = f;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_insn"},  64'(out_instruction), 64'(NOP));
    chk({tag, "_addr"},  out_address, 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int push_idx;
    int pop_idx;
    int cyc;
    logic do_push;
    logic do_pop;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    step();
    chk_empty("reset");

    // Single entry, no bypass on the push cycle.
    in_valid       = 1'b1;
    in_instruction = 32'h00500093;
    in_address     = 64'h0;
    #1;
    chk("nobypass_valid", 64'(out_valid), 64'd0);
    chk("nobypass_insn",  64'(out_instruction), 64'(NOP));
    step();
    in_valid = 1'b0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_insn",  64'(out_instruction), 64'h00500093);
    chk("single_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_valid", 64'(out_valid), 64'd0);
    chk("single_pop_count", 64'(count), 64'd0);

    // Fill to DEPTH, then hold a third entry while stalled.
    drive(1'b1, 64'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h4, 1'b0, 1'b0);
    step();
    chk("full_count", 64'(count), 64'd2);
    chk("full_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 64'h8, 1'b0, 1'b0);
    step();
    chk("stall_count", 64'(count), 64'd2);
    chk("stall_head",  out_address, 64'h0);
    chk("stall_insn",  64'(out_instruction), 64'h00A00013);
    drive(1'b1, 64'h8, 1'b1, 1'b0);
    step();
    chk("pop_full_count", 64'(count), 64'd1);
    chk("pop_full_ready", 64'(in_ready), 64'd1);
    chk("pop_full_head",  out_address, 64'h4);
    drive(1'b1, 64'h8, 1'b0, 1'b0);
    step();
    chk("refill_count", 64'(count), 64'd2);
    chk("refill_head",  out_address, 64'h4);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    step();
    chk("drain1_head",  out_address, 64'h8);
    chk("drain1_insn",  64'(out_instruction), 64'h00A0001B);
    chk("drain1_count", 64'(count), 64'd1);
    step();
    chk("drain2_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Simultaneous push and pop at count 1.
    drive(1'b1, 64'h10, 1'b0, 1'b0);
    step();
    chk("pp_pre_head", out_address, 64'h10);
    drive(1'b1, 64'h14, 1'b1, 1'b0);
    step();
    chk("pp_count", 64'(count), 64'd1);
    chk("pp_head",  out_address, 64'h14);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    step();
    chk("pp_drain_count", 64'(count), 64'd0);

    // Flush with a full queue and both handshakes requested.
    drive(1'b1, 64'h20, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h24, 1'b0, 1'b0);
    step();
    chk("fl_full_count", 64'(count), 64'd2);
    drive(1'b1, 64'h28, 1'b1, 1'b1);
    step();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk_empty("flush_full");

    // Flush at count 1 where a push would otherwise be accepted.
    drive(1'b1, 64'h30, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h34, 1'b1, 1'b1);
    step();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk_empty("flush_one");
    step();
    chk("flush_drop_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 64'h40, 1'b0, 1'b0);
    step();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("post_flush_head",  out_address, 64'h40);
    chk("post_flush_count", 64'(count), 64'd1);

    // Asynchronous reset mid-cycle with two entries queued.
    drive(1'b1, 64'h44, 1'b0, 1'b0);
    step();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("prereset_count", 64'(count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_empty("async_reset");
    step();
    reset = 1'b0;
    step();
    chk_empty("after_reset");

    // Stream six entries with out_ready toggling; order must hold across wraps.
    push_idx = 0;
    pop_idx  = 0;
    cyc      = 0;
    while (pop_idx < 6 && cyc < 60) begin
      in_valid       = (push_idx < 6);
      in_address     = 64'(push_idx * 4);
      in_instruction = 32'h00100013 + 32'(push_idx);
      out_ready      = (cyc % 2 == 0);
      #1;
      do_push = in_valid & in_ready;
      do_pop  = out_valid & out_ready;
      if (do_pop) begin
        chk($sformatf("wrap_addr%0d", pop_idx), out_address, 64'(pop_idx * 4));
        chk($sformatf("wrap_insn%0d", pop_idx), 64'(out_instruction),
            64'(32'h00100013 + 32'(pop_idx)));
        pop_idx++;
      end
      if (do_push) push_idx++;
      step();
      cyc++;
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("wrap_all_popped", 64'(pop_idx), 64'd6);
    chk("wrap_end_count",  64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling instruction queue between the instruction-fetch stage and the decode stage of the pipelined core.
- Captures each fetched {instruction, address} pair and presents them to decode in program order through a valid/ready handshake.
- Absorbs decode stalls without losing fetched instructions.
- Discards all queued entries on a flush (taken branch or jump redirect).

Parameters:
- DEPTH, 2, number of entries; power of two, 2 to 8.
- NOP_INSN, 32'h00000013, instruction word driven on out_instruction when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch stage presents a valid instruction this cycle.
- in_ready  output  1  queue can accept an entry this cycle.
- in_instruction  input  32  fetched instruction word.
- in_address  input  64  address of the fetched instruction.
- flush  input  1  discard all entries (redirect).
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_instruction  output  32  head instruction, or NOP_INSN when empty.
- out_address  output  64  head address, or 0 when empty.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous, takes effect immediately on assertion):
  - rd_ptr = 0, wr_ptr = 0, count = 0, out_valid = 0.
  - out_instruction = NOP_INSN, out_address = 0, in_ready = 1.
  - Storage contents are don't-care.
- Flags:
  - in_ready = (count != DEPTH). Registered-state only; no combinational path from out_ready or in_valid.
  - out_valid = (count != 0).
  - out_instruction and out_address are read combinationally from storage[rd_ptr] when out_valid = 1; otherwise they carry the empty values.
- push = in_valid & in_ready & ~flush.
  - On push: write storage[wr_ptr]; wr_ptr increments modulo DEPTH.
- pop = out_valid & out_ready & ~flush.
  - On pop: rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when push and pop occur together.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. No same-cycle bypass: an empty queue never forwards in_* to out_*.
- Full (count = DEPTH):
  - in_ready = 0; fetch must hold its inputs.
  - A pop in this cycle does not enable a push in the same cycle; in_ready rises the following cycle.
- Empty (count = 0): out_valid = 0 and out_ready is ignored.
- Flush priority:
  - flush = 1 at an edge sets rd_ptr = wr_ptr = 0 and count = 0.
  - It suppresses any push or pop in that cycle; the in_* data is dropped.
  - Next cycle: out_valid = 0, in_ready = 1.
- Wrap-around: pointers wrap from DEPTH-1 to 0; ordering is preserved across the wrap.
- Reset asserted mid-operation: all entries are lost immediately; state is as after reset.
- Inputs are held stable by the producer while in_valid & ~in_ready. The queue does not check this.

Test Plan:
- Reset: assert reset mid-cycle with 2 entries queued -> immediately out_valid=0, count=0, out_instruction=32'h00000013, out_address=0, in_ready=1.
- Single entry: push {32'h00500093, 64'h0}, out_ready=0 -> next cycle out_valid=1, out_instruction=32'h00500093, count=1. Then out_ready=1 -> one cycle later out_valid=0, count=0.
- Fill and stall (DEPTH=2): push addresses 0x0, 0x4, out_ready=0 -> count=2, in_ready=0. A third in_valid with address 0x8 is held and not accepted. One pop -> in_ready=1 the cycle after, then 0x8 enters behind 0x4.
- Simultaneous push and pop at count=1: head 0x10, push 0x14, out_ready=1 -> count stays 1, next head = 0x14.
- Flush priority: count=2, flush=1 with in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, in_ready=1. The pushed instruction never appears on the outputs.
- Wrap-around: stream 6 instructions at addresses 0x0..0x14 with out_ready toggling 1,0,1,0 -> outputs appear in exact order 0x0..0x14, with none dropped or duplicated.
